// File: rtl/lcd_refresh_scheduler_if.sv
// Handshake bundle between the LCD refresh scheduler and the init/draw engines plus host.
// master = scheduler side, slave = engine/host side.
interface lcd_refresh_scheduler_if #(
    parameter int FRAME_W = 8
);
    logic               Init_Done_Sig;
    logic               Draw_Done_Sig;
    logic               Redraw_Req;
    logic               Reinit_Req;
    logic               Init_Start_Sig;
    logic               Draw_Start_Sig;
    logic               Busy;
    logic               Timeout_Err;
    logic [FRAME_W-1:0] Frame_Count;

    modport master (
        input  Init_Done_Sig, Draw_Done_Sig, Redraw_Req, Reinit_Req,
        output Init_Start_Sig, Draw_Start_Sig, Busy, Timeout_Err, Frame_Count
    );

    modport slave (
        output Init_Done_Sig, Draw_Done_Sig, Redraw_Req, Reinit_Req,
        input  Init_Start_Sig, Draw_Start_Sig, Busy, Timeout_Err, Frame_Count
    );
endinterface

// File: rtl/lcd_refresh_scheduler.sv
// Top-level LCD sequencer: init once, draw, then redraw on a refresh timer or host request,
// with host re-init, a per-operation watchdog and a wrapping frame counter.
module lcd_refresh_scheduler #(
    parameter int REFRESH_CYCLES = 50_000_000,
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int CNT_W          = 26,
    parameter int FRAME_W        = 8
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    lcd_refresh_scheduler_if.master bus
);
    typedef enum logic [1:0] {S_INIT, S_DRAW, S_WAIT, S_FAULT} state_t;

    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             r_state,       w_state_nxt;
    logic               r_init_start,  w_init_start_nxt;
    logic               r_draw_start,  w_draw_start_nxt;
    logic               r_busy,        w_busy_nxt;
    logic               r_timeout_err, w_timeout_err_nxt;
    logic               r_reinit_pend, w_reinit_pend_nxt;
    logic [FRAME_W-1:0] r_frame_cnt,   w_frame_cnt_nxt;
    logic [CNT_W-1:0]   r_refresh_cnt, w_refresh_cnt_nxt;
    logic [CNT_W-1:0]   r_wdog_cnt,    w_wdog_cnt_nxt;

    // NOTE: every next-value is given its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt       = r_state;
        w_init_start_nxt  = r_init_start;
        w_draw_start_nxt  = r_draw_start;
        w_timeout_err_nxt = r_timeout_err;
        w_reinit_pend_nxt = r_reinit_pend;
        w_frame_cnt_nxt   = r_frame_cnt;
        w_refresh_cnt_nxt = r_refresh_cnt;
        w_wdog_cnt_nxt    = r_wdog_cnt;

        case (r_state)
            S_INIT: begin
                if (bus.Reinit_Req) w_reinit_pend_nxt = 1'b1;
                if (!r_init_start) begin
                    // Only reached on the first edge after reset; this edge counts as state entry.
                    w_init_start_nxt = 1'b1;
                    w_wdog_cnt_nxt   = '0;
                end else if (bus.Init_Done_Sig) begin
                    w_init_start_nxt  = 1'b0;
                    w_draw_start_nxt  = 1'b1;
                    w_reinit_pend_nxt = 1'b0;
                    w_wdog_cnt_nxt    = '0;
                    w_state_nxt       = S_DRAW;
                end else if (r_wdog_cnt == TIMEOUT_LAST) begin
                    w_init_start_nxt  = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_FAULT;
                end else begin
                    w_wdog_cnt_nxt = r_wdog_cnt + 1'b1;
                end
            end

            S_DRAW: begin
                if (bus.Reinit_Req) w_reinit_pend_nxt = 1'b1;
                if (bus.Draw_Done_Sig) begin
                    w_draw_start_nxt = 1'b0;
                    w_frame_cnt_nxt  = r_frame_cnt + 1'b1;
                    if (r_reinit_pend || bus.Reinit_Req) begin
                        w_init_start_nxt = 1'b1;
                        w_wdog_cnt_nxt   = '0;
                        w_state_nxt      = S_INIT;
                    end else begin
                        w_refresh_cnt_nxt = '0;
                        w_state_nxt       = S_WAIT;
                    end
                end else if (r_wdog_cnt == TIMEOUT_LAST) begin
                    w_draw_start_nxt  = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_FAULT;
                end else begin
                    w_wdog_cnt_nxt = r_wdog_cnt + 1'b1;
                end
            end

            S_WAIT: begin
                if (bus.Reinit_Req) begin
                    w_init_start_nxt = 1'b1;
                    w_wdog_cnt_nxt   = '0;
                    w_state_nxt      = S_INIT;
                end else if (bus.Redraw_Req || (r_refresh_cnt == REFRESH_LAST)) begin
                    w_draw_start_nxt = 1'b1;
                    w_wdog_cnt_nxt   = '0;
                    w_state_nxt      = S_DRAW;
                end else begin
                    w_refresh_cnt_nxt = r_refresh_cnt + 1'b1;
                end
            end

            S_FAULT: begin
                if (bus.Reinit_Req) begin
                    w_init_start_nxt  = 1'b1;
                    w_timeout_err_nxt = 1'b0;
                    w_reinit_pend_nxt = 1'b0;
                    w_wdog_cnt_nxt    = '0;
                    w_state_nxt       = S_INIT;
                end
            end

            default: w_state_nxt = S_INIT;
        endcase

        w_busy_nxt = (w_state_nxt == S_INIT) || (w_state_nxt == S_DRAW);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state       <= S_INIT;
            r_init_start  <= 1'b0;
            r_draw_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_reinit_pend <= 1'b0;
            r_frame_cnt   <= '0;
            r_refresh_cnt <= '0;
            r_wdog_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_init_start  <= w_init_start_nxt;
            r_draw_start  <= w_draw_start_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_reinit_pend <= w_reinit_pend_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_refresh_cnt <= w_refresh_cnt_nxt;
            r_wdog_cnt    <= w_wdog_cnt_nxt;
        end
    end

    assign bus.Init_Start_Sig = r_init_start;
    assign bus.Draw_Start_Sig = r_draw_start;
    assign bus.Busy           = r_busy;
    assign bus.Timeout_Err    = r_timeout_err;
    assign bus.Frame_Count    = r_frame_cnt;
endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Bench for lcd_refresh_scheduler: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a phase/elapsed-time model of the scheduler.
module tb_lcd_refresh_scheduler;
    localparam int REFRESH = 20;
    localparam int TIMEOUT = 100;
    localparam int FRAME_W = 8;

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    lcd_refresh_scheduler_if #(.FRAME_W(FRAME_W)) bus ();

    lcd_refresh_scheduler #(
        .REFRESH_CYCLES(REFRESH),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (8),
        .FRAME_W       (FRAME_W)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: which operation is running, how long its Start has been up, how long idle.
    typedef enum {P_INIT, P_DRAW, P_WAIT, P_FAULT} phase_e;
    phase_e m_phase;
    bit     m_started, m_pend, m_err;
    int     m_age, m_idle, m_frame;

    task automatic m_reset();
        m_phase = P_INIT; m_started = 0; m_pend = 0; m_err = 0;
        m_age = 0; m_idle = 0; m_frame = 0;
    endtask

    task automatic m_enter(input phase_e p);
        m_phase = p;
        m_started = 1;
        m_age = 1;
        m_idle = 1;
        if (p == P_FAULT) m_err = 1;
    endtask

    task automatic m_step(input bit id, input bit dd, input bit rd, input bit ri);
        case (m_phase)
            P_INIT: begin
                if (ri) m_pend = 1;
                if (!m_started) begin m_started = 1; m_age = 1; end
                else if (id) begin m_pend = 0; m_enter(P_DRAW); end
                else if (m_age == TIMEOUT) m_enter(P_FAULT);
                else m_age++;
            end
            P_DRAW: begin
                if (ri) m_pend = 1;
                if (dd) begin
                    m_frame = (m_frame + 1) % (1 << FRAME_W);
                    m_enter(m_pend ? P_INIT : P_WAIT);
                end else if (m_age == TIMEOUT) m_enter(P_FAULT);
                else m_age++;
            end
            P_WAIT: begin
                if (ri) m_enter(P_INIT);
                else if (rd || m_idle == REFRESH) m_enter(P_DRAW);
                else m_idle++;
            end
            P_FAULT: begin
                if (ri) begin m_err = 0; m_pend = 0; m_enter(P_INIT); end
            end
        endcase
    endtask

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) m_reset();
        else m_step(bus.Init_Done_Sig, bus.Draw_Done_Sig, bus.Redraw_Req, bus.Reinit_Req);
        #1;
        check("model_init_start", bus.Init_Start_Sig, (m_phase == P_INIT) && m_started);
        check("model_draw_start", bus.Draw_Start_Sig, m_phase == P_DRAW);
        check("model_busy", bus.Busy, ((m_phase == P_INIT) && m_started) || (m_phase == P_DRAW));
        check("model_timeout_err", bus.Timeout_Err, m_err);
        check("model_frame_count", bus.Frame_Count, m_frame);
    end

    // Drive a one-cycle request/done pattern; called at a negedge, returns at the next negedge.
    task automatic pulse(input bit id, input bit dd, input bit rd, input bit ri);
        bus.Init_Done_Sig = id; bus.Draw_Done_Sig = dd;
        bus.Redraw_Req    = rd; bus.Reinit_Req    = ri;
        @(negedge CLK);
        bus.Init_Done_Sig = 0; bus.Draw_Done_Sig = 0;
        bus.Redraw_Req    = 0; bus.Reinit_Req    = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_init_start"}, bus.Init_Start_Sig, 0);
        check({tag, "_draw_start"}, bus.Draw_Start_Sig, 0);
        check({tag, "_busy"}, bus.Busy, 0);
        check({tag, "_timeout_err"}, bus.Timeout_Err, 0);
        check({tag, "_frame_count"}, bus.Frame_Count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        bus.Init_Done_Sig = 0; bus.Draw_Done_Sig = 0;
        bus.Redraw_Req    = 0; bus.Reinit_Req    = 0;
        #1 RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RSTn = 1'b1;

        // Init handshake: Start up on cycles 1..10, Done seen at edge 11.
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            check("init_start_window", bus.Init_Start_Sig, 1);
            check("busy_in_init", bus.Busy, 1);
        end
        pulse(1, 0, 0, 0);
        check("init_start_dropped", bus.Init_Start_Sig, 0);
        check("draw_start_rose", bus.Draw_Start_Sig, 1);
        check("busy_in_draw", bus.Busy, 1);

        // First draw, then auto-refresh exactly REFRESH cycles later.
        repeat (4) @(negedge CLK);
        pulse(0, 1, 0, 0);
        check("frame_after_first", bus.Frame_Count, 1);
        check("draw_start_low_wait", bus.Draw_Start_Sig, 0);
        check("busy_low_wait", bus.Busy, 0);
        n = 0;
        while (!bus.Draw_Start_Sig && n < 3 * REFRESH) begin @(negedge CLK); n++; end
        check("auto_refresh_delay", n, REFRESH);
        repeat (3) @(negedge CLK);
        pulse(0, 1, 0, 0);
        check("frame_after_second", bus.Frame_Count, 2);

        // Host redraw part-way through the wait.
        repeat (5) @(negedge CLK);
        pulse(0, 0, 1, 0);
        check("redraw_starts_draw", bus.Draw_Start_Sig, 1);
        pulse(0, 1, 0, 0);
        check("frame_after_redraw", bus.Frame_Count, 3);
        pulse(0, 0, 1, 1);
        check("reinit_beats_redraw_init", bus.Init_Start_Sig, 1);
        check("reinit_beats_redraw_draw", bus.Draw_Start_Sig, 0);

        // Reinit and redraw requests during a draw.
        pulse(1, 0, 0, 0);
        repeat (2) @(negedge CLK);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 0);
        check("mid_draw_still_draw", bus.Draw_Start_Sig, 1);
        check("mid_draw_no_init", bus.Init_Start_Sig, 0);
        pulse(0, 1, 0, 0);
        check("pending_reinit_init", bus.Init_Start_Sig, 1);
        check("frame_with_reinit", bus.Frame_Count, 4);

        // Watchdog expiry on a withheld Draw_Done.
        pulse(1, 0, 0, 0);
        n = 1;
        while (bus.Draw_Start_Sig && n < 3 * TIMEOUT) begin @(negedge CLK); n++; end
        check("draw_start_high_cycles", n - 1, TIMEOUT);
        check("timeout_err_set", bus.Timeout_Err, 1);
        repeat (5) @(negedge CLK);
        check("timeout_err_sticky", bus.Timeout_Err, 1);
        check("fault_no_start", bus.Init_Start_Sig | bus.Draw_Start_Sig, 0);
        pulse(0, 0, 0, 1);
        check("fault_exit_init", bus.Init_Start_Sig, 1);
        check("fault_exit_err_clr", bus.Timeout_Err, 0);

        // Done arriving on the last allowed cycle completes normally.
        pulse(1, 0, 0, 0);
        repeat (TIMEOUT - 1) @(negedge CLK);
        pulse(0, 1, 0, 0);
        check("late_done_no_err", bus.Timeout_Err, 0);
        check("late_done_frame", bus.Frame_Count, 5);
        check("late_done_draw_low", bus.Draw_Start_Sig, 0);

        // Frame counter wrap.
        for (int k = 0; k < 250; k++) begin
            pulse(0, 0, 1, 0);
            pulse(0, 1, 0, 0);
        end
        check("frame_max", bus.Frame_Count, 255);
        pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 0);
        check("frame_wrap", bus.Frame_Count, 0);

        // Asynchronous reset in the middle of a draw.
        pulse(0, 0, 1, 0);
        repeat (3) @(negedge CLK);
        #3 RSTn = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        check("restart_init_start", bus.Init_Start_Sig, 1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            bus.Init_Done_Sig = ($urandom_range(0, 7) == 0);
            bus.Draw_Done_Sig = ($urandom_range(0, 39) == 0);
            bus.Redraw_Req    = ($urandom_range(0, 29) == 0);
            bus.Reinit_Req    = ($urandom_range(0, 59) == 0);
            if (i == 2000) begin
                #3 RSTn = 1'b0;
                @(negedge CLK);
                RSTn = 1'b1;
            end
        end
        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
